fc_layer_engine: RTL

//  Runtime-configurable fully-connected layer engine for the CNN accelerator.
//  - Loads an N_IN-word input vector from DRAM into a local buffer.
//  - For each of N_OUT neurons, streams N_IN weights plus one bias, computes a fixed-point MAC, bias add, optional ReLU and saturation.
//  - Writes each neuron result to DRAM.
//  - Multi-layer classifiers (e.g. 400->120->10) run as back-to-back jobs chained through DRAM.

---
 rtl/cnn_pkg.sv | 35 +++
 rtl/fc_mac_unit.sv | 57 +++++
 rtl/fc_layer_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator engines.
//   fc_state_t   : control states of the fully-connected layer engine
//   sat()        : signed clamp of a 64-bit value to a w-bit two's-complement range
//   FC_FRAC_BITS : default fixed-point fraction width
//   DRAM_*_BASE  : default DRAM word-address regions used by layer jobs
package cnn_pkg;

  localparam int unsigned FC_FRAC_BITS = 16;

  localparam int unsigned DRAM_IF_BASE = 32'h0_0000;
  localparam int unsigned DRAM_WT_BASE = 32'h0_4000;
  localparam int unsigned DRAM_BS_BASE = 32'h3_F000;
  localparam int unsigned DRAM_OF_BASE = 32'h3_F800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_IF,
    ST_MAC,
    ST_BIAS,
    ST_WR,
    ST_DONE
  } fc_state_t;

  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Fixed-point datapath of the FC engine.
//   clk, srstn : clock, synchronous active-low reset
//   clr        : clear the accumulator
//   mac_en     : acc += (data_in * coef) >>> FRAC_BITS, clamped to accumulator range
//   bias_en    : res <= sat(acc + data_in) to DATA_WIDTH, then ReLU when relu=1
//   relu       : clamp negative results to 0
//   data_in    : weight (MAC) or bias (BIAS) word from DRAM
//   coef       : input-vector word from the local buffer
//   res        : registered neuron result
module fc_mac_unit
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = FC_FRAC_BITS,
  parameter int unsigned ACC_GUARD  = 8
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  clr,
  input  logic                  mac_en,
  input  logic                  bias_en,
  input  logic                  relu,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] coef,
  output logic [DATA_WIDTH-1:0] res
);

  localparam int unsigned AW = DATA_WIDTH + ACC_GUARD;

  logic signed [AW-1:0]           acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [63:0]             acc_sum;
  logic signed [63:0]             bias_sum;
  logic signed [63:0]             res_sat;
  logic        [DATA_WIDTH-1:0]   res_next;

  always_comb begin
    prod     = $signed(data_in) * $signed(coef);
    // arithmetic shift floors the full-width product before accumulation
    acc_sum  = 64'(acc) + 64'(prod >>> FRAC_BITS);
    bias_sum = 64'(acc) + 64'($signed(data_in));
    res_sat  = sat(bias_sum, DATA_WIDTH);
    res_next = (relu && res_sat < 0) ? '0 : DATA_WIDTH'(res_sat);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (mac_en) acc <= AW'(sat(acc_sum, AW));
      if (bias_en)     res <= res_next;
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: loads an input vector from DRAM into a local
// buffer, then for each neuron streams weights and a bias through fc_mac_unit
// and writes the result back to DRAM.
//   clk, srstn                 : clock, synchronous active-low reset
//   start                      : job start, sampled only in IDLE
//   cfg_num_in, cfg_num_out    : vector length / neuron count
//   cfg_{if,wt,bs,of}_base     : DRAM regions (input, weights, biases, outputs)
//   cfg_relu                   : clamp negative results to 0
//   dram_valid, data_in        : read acknowledge and read data
//   dram_en_rd, addr_in        : read request and address (held until ack)
//   dram_en_wr, addr_out,
//   data_out                   : one-cycle posted write
//   busy, done, err            : job active, end-of-job pulse, sticky config error
module fc_layer_engine
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned FRAC_BITS  = FC_FRAC_BITS,
  parameter int unsigned MAX_IN     = 400,
  parameter int unsigned MAX_OUT    = 1024,
  parameter int unsigned ACC_GUARD  = 8
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [15:0]           cfg_num_in,
  input  logic [15:0]           cfg_num_out,
  input  logic [ADDR_WIDTH-1:0] cfg_if_base,
  input  logic [ADDR_WIDTH-1:0] cfg_wt_base,
  input  logic [ADDR_WIDTH-1:0] cfg_bs_base,
  input  logic [ADDR_WIDTH-1:0] cfg_of_base,
  input  logic                  cfg_relu,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IDXW = $clog2(MAX_IN);

  fc_state_t state, state_next;

  logic [15:0]           num_in, num_out, k, n;
  logic [ADDR_WIDTH-1:0] if_base, bs_base, of_base, wt_ptr;
  logic                  relu;
  logic                  cfg_ok, last_tap, last_neuron;
  logic                  ld_en, mac_en, bias_en, acc_clr;
  logic [DATA_WIDTH-1:0] ibuf [MAX_IN];
  logic [DATA_WIDTH-1:0] res;

  assign cfg_ok = (cfg_num_in  != '0) && (cfg_num_in  <= 16'(MAX_IN)) &&
                  (cfg_num_out != '0) && (cfg_num_out <= 16'(MAX_OUT));
  assign last_tap    = (k == num_in  - 16'd1);
  assign last_neuron = (n == num_out - 16'd1);

  always_ff @(posedge clk) begin
    if (!srstn) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    dram_en_rd = 1'b0;
    dram_en_wr = 1'b0;
    addr_in    = '0;
    addr_out   = '0;
    data_out   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    ld_en      = 1'b0;
    mac_en     = 1'b0;
    bias_en    = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (start) state_next = cfg_ok ? ST_LD_IF : ST_DONE;
      end
      ST_LD_IF: begin
        busy       = 1'b1;
        dram_en_rd = 1'b1;
        addr_in    = if_base + ADDR_WIDTH'(k);
        ld_en      = dram_valid;
        if (dram_valid && last_tap) state_next = ST_MAC;
      end
      ST_MAC: begin
        busy       = 1'b1;
        dram_en_rd = 1'b1;
        addr_in    = wt_ptr;
        mac_en     = dram_valid;
        if (dram_valid && last_tap) state_next = ST_BIAS;
      end
      ST_BIAS: begin
        busy       = 1'b1;
        dram_en_rd = 1'b1;
        addr_in    = bs_base + ADDR_WIDTH'(n);
        bias_en    = dram_valid;
        if (dram_valid) state_next = ST_WR;
      end
      ST_WR: begin
        busy       = 1'b1;
        dram_en_wr = 1'b1;
        addr_out   = of_base + ADDR_WIDTH'(n);
        data_out   = res;
        acc_clr    = 1'b1;
        state_next = last_neuron ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Weights of consecutive neurons are contiguous, so one running pointer
  // replaces the n*num_in+k multiply.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      num_in  <= '0;
      num_out <= '0;
      if_base <= '0;
      bs_base <= '0;
      of_base <= '0;
      wt_ptr  <= '0;
      relu    <= 1'b0;
      k       <= '0;
      n       <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          num_in  <= cfg_num_in;
          num_out <= cfg_num_out;
          if_base <= cfg_if_base;
          bs_base <= cfg_bs_base;
          of_base <= cfg_of_base;
          wt_ptr  <= cfg_wt_base;
          relu    <= cfg_relu;
          k       <= '0;
          n       <= '0;
          err     <= !cfg_ok;
        end
        ST_LD_IF: if (dram_valid) k <= last_tap ? '0 : k + 16'd1;
        ST_MAC: if (dram_valid) begin
          wt_ptr <= wt_ptr + ADDR_WIDTH'(1);
          k      <= last_tap ? '0 : k + 16'd1;
        end
        ST_WR:   n <= n + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) ibuf[k[IDXW-1:0]] <= data_in;
  end

  fc_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_GUARD  (ACC_GUARD)
  ) u_mac (
    .clk     (clk),
    .srstn   (srstn),
    .clr     (acc_clr),
    .mac_en  (mac_en),
    .bias_en (bias_en),
    .relu    (relu),
    .data_in (data_in),
    .coef    (ibuf[k[IDXW-1:0]]),
    .res     (res)
  );

endmodule
